// File: rtl/cp0_unit.sv
// Coprocessor-0 responder for the decode stage.
// Serves mfc0 reads, commits mtc0 writes, takes syscall and six hardware
// interrupts, and handles eret. Exception entry flushes IF/ID and redirects
// fetch to the handler; eret redirects fetch back to EPC.
module cp0_unit #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
    parameter logic [31:0] PRID         = 32'h0016_2016
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [4:0]  CPAddr,
    input  logic [31:0] CPWData,
    input  logic        CPWrite,
    input  logic        ERet,
    input  logic        SWInt,
    input  logic [31:0] PC_in,
    input  logic        Stall,
    input  logic [5:0]  HWInt,
    output logic [31:0] CPRData,
    output logic        ExcStall,
    output logic        RedirSel,
    output logic [31:0] RedirPC,
    output logic [31:0] EPC,
    output logic        InHandler
);

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_ENTER,
        ST_HANDLER
    } state_t;

    state_t      state;
    logic [5:0]  sr_im;
    logic        sr_exl;
    logic        sr_ie;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [31:0] epc_q;

    logic int_req;
    logic sys_req;
    logic take;
    logic eret_go;
    logic wr_en;
    logic wr_sr;
    logic wr_epc;

    // Request qualification: interrupts need IE and a matching mask bit,
    // and nothing is taken while already in the handler (EXL) or mid-entry.
    assign int_req = (|(cause_ip & sr_im)) & sr_ie & ~sr_exl;
    assign sys_req = SWInt & ~sr_exl;
    assign take    = (int_req | sys_req) & ~Stall & (state == ST_RUN);
    assign eret_go = (state == ST_HANDLER) & ERet & ~Stall;

    // An mtc0 in the same cycle as an exception entry belongs to the
    // flushed instruction stream, so it is dropped rather than retried.
    assign wr_en  = CPWrite & ~Stall & ~take;
    assign wr_sr  = wr_en & (CPAddr == REG_SR);
    assign wr_epc = wr_en & (CPAddr == REG_EPC);

    // mfc0 read mux; the read sees register contents before any same-cycle write.
    always_comb begin
        // NOTE: default assignment first so every path drives CPRData and no latch is inferred.
        CPRData = 32'h0;
        case (CPAddr)
            REG_SR:    CPRData = {16'h0, sr_im, 8'h0, sr_exl, sr_ie};
            REG_CAUSE: CPRData = {16'h0, cause_ip, 3'b000, cause_exc, 2'b00};
            REG_EPC:   CPRData = epc_q;
            REG_PRID:  CPRData = PRID;
            default:   CPRData = 32'h0;
        endcase
    end

    // Redirect control: the entry redirect is a decode of the registered
    // ENTER state; the eret redirect must act in the same cycle as the eret.
    always_comb begin
        ExcStall = 1'b0;
        RedirSel = 1'b0;
        RedirPC  = 32'h0;
        if (state == ST_ENTER) begin
            ExcStall = 1'b1;
            RedirSel = 1'b1;
            RedirPC  = HANDLER_ADDR;
        end else if (eret_go) begin
            ExcStall = 1'b1;
            RedirSel = 1'b1;
            RedirPC  = epc_q;
        end
    end

    assign EPC       = epc_q;
    assign InHandler = sr_exl;

    // CP0 register file and exception FSM.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state     <= ST_RUN;
            sr_im     <= 6'h0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_ip  <= 6'h0;
            cause_exc <= 5'h0;
            epc_q     <= 32'h0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            cause_ip <= HWInt;

            if (take) begin
                epc_q     <= {PC_in[31:2], 2'b00};
                sr_exl    <= 1'b1;
                cause_exc <= int_req ? EXC_INT : EXC_SYS;
            end

            if (wr_sr) begin
                sr_im  <= CPWData[15:10];
                sr_exl <= CPWData[1];
                sr_ie  <= CPWData[0];
            end

            if (wr_epc) begin
                epc_q <= {CPWData[31:2], 2'b00};
            end

            // Later assignment wins: eret always leaves the handler with EXL clear.
            if (eret_go) begin
                sr_exl <= 1'b0;
            end

            case (state)
                ST_RUN: begin
                    if (take) state <= ST_ENTER;
                end
                ST_ENTER: begin
                    state <= ST_HANDLER;
                end
                ST_HANDLER: begin
                    if (eret_go || (wr_sr && !CPWData[1]) || !sr_exl) state <= ST_RUN;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

endmodule
